// File: rtl/pipelined_csel_adder_pkg.sv
// ============================================================================
// Module   : pipelined_csel_adder_pkg
// Brief    : Mode encoding and stage-count helper for the pipelined adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipelined_csel_adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int calc_nslice(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_csel_adder_csel.sv
// ============================================================================
// Module   : csel_slice
// Brief    : Combinational SLICE-bit carry-select adder with MSB carry tap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csel_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [SLICE:0]   w_c0;
   logic [SLICE:0]   w_c1;
   logic [SLICE-1:0] w_s0;
   logic [SLICE-1:0] w_s1;

   // Both ripple chains run in parallel; the real carry only drives the muxes.
   always_comb begin
      w_c0    = '0;
      w_c1    = '0;
      w_s0    = '0;
      w_s1    = '0;
      w_c0[0] = 1'b0;
      w_c1[0] = 1'b1;
      for (int i = 0; i < SLICE; i++) begin
         w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
         w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
         w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
         w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
      end
   end

   assign sum  = cin ? w_s1 : w_s0;
   assign cout = cin ? w_c1[SLICE] : w_c0[SLICE];
   assign cmsb = cin ? w_c1[SLICE-1] : w_c0[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_csel_adder.sv
// ============================================================================
// Module   : pipelined_csel_adder
// Brief    : WIDTH-bit add/sub, one SLICE-bit carry-select group per stage,
//            valid/ready on both sides with a global stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_csel_adder
   import pipelined_csel_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = calc_nslice(WIDTH, SLICE);

   if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
      $error("pipelined_csel_adder: WIDTH must be a positive multiple of SLICE");
   end

   logic              w_advance;
   logic [NSLICE-1:0] valid_q;
   logic [NSLICE-1:0] carry_q;
   logic [NSLICE-1:0] carry_d;
   logic [NSLICE-1:0] w_cin;
   logic              msbc_q;
   logic [WIDTH-1:0]  a_q      [NSLICE];
   logic [WIDTH-1:0]  b_q      [NSLICE];
   logic [WIDTH-1:0]  sum_q    [NSLICE];
   logic [WIDTH-1:0]  a_d      [NSLICE];
   logic [WIDTH-1:0]  b_d      [NSLICE];
   logic [WIDTH-1:0]  sum_d    [NSLICE];
   logic [WIDTH-1:0]  w_sum_in [NSLICE];
   logic [SLICE-1:0]  w_ssum   [NSLICE];
   logic              w_cmsb   [NSLICE];

   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   for (genvar k = 0; k < NSLICE; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign a_d[k]      = a;
         assign b_d[k]      = (sub == MODE_ADD) ? b : ~b;
         assign w_cin[k]    = (sub == MODE_SUB) ? 1'b1 : cin;
         assign w_sum_in[k] = '0;
      end else begin : g_tail
         assign a_d[k]      = a_q[k-1];
         assign b_d[k]      = b_q[k-1];
         assign w_cin[k]    = carry_q[k-1];
         assign w_sum_in[k] = sum_q[k-1];
      end

      csel_slice #(
         .SLICE (SLICE)
      ) u_slice (
         .a    (a_d[k][k*SLICE +: SLICE]),
         .b    (b_d[k][k*SLICE +: SLICE]),
         .cin  (w_cin[k]),
         .sum  (w_ssum[k]),
         .cout (carry_d[k]),
         .cmsb (w_cmsb[k])
      );

      // Bits above the already-resolved slices are still zero, so OR merges.
      assign sum_d[k] = w_sum_in[k] | (WIDTH'(w_ssum[k]) << (k * SLICE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         msbc_q  <= 1'b0;
         for (int k = 0; k < NSLICE; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (w_advance) begin
         valid_q[0] <= in_valid;
         for (int k = 1; k < NSLICE; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
         carry_q <= carry_d;
         msbc_q  <= w_cmsb[NSLICE-1];
         for (int k = 0; k < NSLICE; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign out_valid = valid_q[NSLICE-1];
   assign sum       = sum_q[NSLICE-1];
   assign cout      = carry_q[NSLICE-1];
   assign ovf       = msbc_q ^ carry_q[NSLICE-1];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
// ============================================================================
// Module   : tb_pipelined_csel_adder
// Brief    : Directed and randomised checks of the pipelined carry-select adder.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipelined_csel_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        in_ready;
   logic        out_valid;
   logic        cout;
   logic        ovf;
   logic [15:0] sum;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipelined_csel_adder #(
      .WIDTH (16),
      .SLICE (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mcin, input logic msub);
      logic [15:0] bb;
      logic        c;
      logic [16:0] full;
      logic        v;
      bb   = msub ? ~mb : mb;
      c    = msub ? 1'b1 : mcin;
      full = {1'b0, ma} + {1'b0, bb} + {16'b0, c};
      v    = (ma[15] == bb[15]) && (full[15] != ma[15]);
      return {v, full[16], full[15:0]};
   endfunction

   // Sends one transaction into an empty pipeline and waits for its result.
   task automatic run_single(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                             input logic tsub, output logic [17:0] res, output int lat);
      @(posedge clk); #1;
      a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      res = {ovf, cout, sum};
   endtask

   task automatic test_reset();
      logic seen;
      #1;
      n_cmp++;
      if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: got ov=%b sum=%h co=%b ovf=%b ir=%b, want ov=0 sum=0000 co=0 ovf=0 ir=1",
                  out_valid, sum, cout, ovf, in_ready);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = 16'(16'h1000 * (i + 1)); b = 16'h0001; cin = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, sum} !== {1'b1, 16'h1001}) begin
         n_err++;
         $display("FAIL reset_prefill: got ov=%b sum=%h, want ov=1 sum=1001", out_valid, sum);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, sum, cout, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_async: got ov=%b sum=%h co=%b ir=%b, want ov=0 sum=0000 co=0 ir=1",
                  out_valid, sum, cout, in_ready);
      end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flush: got out_valid seen=%b after reset, want 0", seen);
      end
   endtask

   task automatic test_add();
      logic [17:0] res;
      int lat;
      run_single(16'h00FF, 16'h0001, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (lat !== 4) begin
         n_err++;
         $display("FAIL add_latency: got %0d cycles, want 4", lat);
      end
      n_cmp++;
      if (res !== {1'b0, 1'b0, 16'h0100}) begin
         n_err++;
         $display("FAIL add_00FF: got {ovf,cout,sum}=%h, want %h", res, {1'b0, 1'b0, 16'h0100});
      end
      run_single(16'hFFFF, 16'h0001, 1'b1, 1'b0, res, lat);
      n_cmp++;
      if (res !== {1'b0, 1'b1, 16'h0001}) begin
         n_err++;
         $display("FAIL add_FFFF_cin: got %h, want %h", res, {1'b0, 1'b1, 16'h0001});
      end
      run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (res !== {1'b1, 1'b0, 16'h8000}) begin
         n_err++;
         $display("FAIL add_ovf: got %h, want %h", res, {1'b1, 1'b0, 16'h8000});
      end
      run_single(16'h1234, 16'h4321, 1'b1, 1'b0, res, lat);
      n_cmp++;
      if (res !== {1'b0, 1'b0, 16'h5556}) begin
         n_err++;
         $display("FAIL add_mixed: got %h, want %h", res, {1'b0, 1'b0, 16'h5556});
      end
   endtask

   task automatic test_sub();
      logic [17:0] res;
      int lat;
      run_single(16'h8000, 16'h0001, 1'b0, 1'b1, res, lat);
      n_cmp++;
      if (res !== {1'b1, 1'b1, 16'h7FFF}) begin
         n_err++;
         $display("FAIL sub_8000: got %h, want %h", res, {1'b1, 1'b1, 16'h7FFF});
      end
      run_single(16'h0003, 16'h0005, 1'b0, 1'b1, res, lat);
      n_cmp++;
      if (res !== {1'b0, 1'b0, 16'hFFFE}) begin
         n_err++;
         $display("FAIL sub_borrow: got %h, want %h", res, {1'b0, 1'b0, 16'hFFFE});
      end
      run_single(16'h0005, 16'h0005, 1'b1, 1'b1, res, lat);
      n_cmp++;
      if (res !== {1'b0, 1'b1, 16'h0000}) begin
         n_err++;
         $display("FAIL sub_cin_ignored: got %h, want %h", res, {1'b0, 1'b1, 16'h0000});
      end
      run_single(16'h0000, 16'h8000, 1'b0, 1'b1, res, lat);
      n_cmp++;
      if (res !== {1'b1, 1'b0, 16'h8000}) begin
         n_err++;
         $display("FAIL sub_neg_min: got %h, want %h", res, {1'b1, 1'b0, 16'h8000});
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] got [8];
      int          gcyc [8];
      int          ng;
      logic [15:0] es;
      logic [7:0]  ovf_tab;
      ovf_tab = 8'b0100_0000;   // only 0x7777+0x0F0F overflows
      ng = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_valid = (c < 8); a = 16'(16'h1111 * (c + 1)); b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
         @(negedge clk);
         if (out_valid && ng < 8) begin
            got[ng] = {ovf, cout, sum}; gcyc[ng] = c; ng++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (ng !== 8) begin
         n_err++;
         $display("FAIL b2b_count: got %0d results, want 8", ng);
      end
      for (int k = 0; k < ng; k++) begin
         es = 16'(16'h1111 * (k + 1) + 16'h0F0F);
         n_cmp++;
         if (got[k] !== {ovf_tab[k], 1'b0, es} || gcyc[k] !== k + 4) begin
            n_err++;
            $display("FAIL b2b_result%0d: got %h at cycle %0d, want %h at cycle %0d",
                     k, got[k], gcyc[k], {ovf_tab[k], 1'b0, es}, k + 4);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] got [10];
      int          k_in;
      int          ng;
      k_in = 0;
      ng = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
         in_valid = (k_in < 10); a = 16'(16'h0100 * k_in); b = 16'h0003; cin = 1'b0; sub = 1'b0;
         out_ready = !(c >= 4 && c <= 8);
         @(negedge clk);
         if (c >= 4 && c <= 8) begin
            n_cmp++;
            if ({in_ready, out_valid, sum} !== {1'b0, 1'b1, 16'h0003}) begin
               n_err++;
               $display("FAIL bp_hold_c%0d: got ir=%b ov=%b sum=%h, want ir=0 ov=1 sum=0003",
                        c, in_ready, out_valid, sum);
            end
         end
         if (out_valid && out_ready) begin
            if (ng < 10) got[ng] = sum;
            ng++;
         end
         if (in_valid && in_ready) k_in++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (ng !== 10) begin
         n_err++;
         $display("FAIL bp_count: got %0d deliveries, want 10", ng);
      end
      for (int k = 0; k < 10 && k < ng; k++) begin
         n_cmp++;
         if (got[k] !== 16'(16'h0100 * k + 16'h0003)) begin
            n_err++;
            $display("FAIL bp_order%0d: got %h, want %h", k, got[k], 16'(16'h0100 * k + 16'h0003));
         end
      end
   endtask

   task automatic test_random();
      logic [17:0] q [$];
      logic [17:0] e;
      logic [17:0] hold_val;
      logic        hold_pend;
      int          acc;
      int          cyc;
      acc = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
      @(posedge clk); #1;
      while ((acc < 10000 || q.size() > 0) && cyc < 60000) begin
         in_valid  = (acc < 10000) && ($urandom_range(0, 3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold_pend) begin
            n_cmp++;
            if ({out_valid, ovf, cout, sum} !== {1'b1, hold_val}) begin
               n_err++;
               $display("FAIL rand_hold: got ov=%b %h, want ov=1 %h", out_valid, {ovf, cout, sum}, hold_val);
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = {ovf, cout, sum};
         if (out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL rand_extra: got unexpected result %h, want none", {ovf, cout, sum});
            end else begin
               e = q.pop_front();
               if ({ovf, cout, sum} !== e) begin
                  n_err++;
                  $display("FAIL rand_result: got {ovf,cout,sum}=%h, want %h", {ovf, cout, sum}, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            acc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (acc !== 10000 || q.size() !== 0) begin
         n_err++;
         $display("FAIL rand_timeout: got %0d accepted, %0d pending, want 10000 accepted, 0 pending",
                  acc, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
